// File: rtl/s_mem_arbiter.sv
// Registered ownership arbiter for the single-port RC4 S memory; forwards each read result to its issuer.
// Optional macro S_MEM_ARB_ROUND_ROBIN_EN: round-robin arbitration (default build: fixed priority, index 0 wins).
module s_mem_arbiter #(
   parameter int N_REQ  = 3,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ-1:0]        req_we,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   input  logic [N_REQ*DATA_W-1:0] req_wdata,
   output logic [N_REQ-1:0]        gnt,
   output logic [N_REQ-1:0]        rvalid,
   output logic [DATA_W-1:0]       rdata,
   output logic                    busy,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [DATA_W-1:0]       mem_data,
   output logic                    mem_wren,
   input  logic [DATA_W-1:0]       mem_q
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef logic [IDX_W-1:0] idx_t;
   typedef enum logic { IDLE, OWNED } state_t;
   typedef struct packed {
      logic valid;
      idx_t idx;
   } tag_t;

   state_t           state_q, state_d;
   idx_t             owner_q, owner_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [N_REQ-1:0] eligible;
   logic             pick_found;
   idx_t             pick_idx;
   logic             grant_now;
   logic             owner_req;
   logic             active;
   logic             read_issue;
   tag_t             tag_q [RD_LAT];

   // The releasing owner is excluded on its release edge; in IDLE gnt_q is zero.
   assign eligible  = req & ~gnt_q;
   assign owner_req = req[owner_q];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= '0;
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         gnt_q   <= gnt_d;
      end
   end

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      gnt_d     = gnt_q;
      grant_now = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_found) grant_now = 1'b1;
         end
         OWNED: begin
            if (!owner_req) begin
               if (pick_found) begin
                  grant_now = 1'b1;
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
               end
            end
         end
      endcase
      if (grant_now) begin
         state_d = OWNED;
         owner_d = pick_idx;
         gnt_d   = N_REQ'(1) << pick_idx;
      end
   end

`ifdef S_MEM_ARB_ROUND_ROBIN_EN
   // rr_ptr_q holds the index that gets first look at the next arbitration.
   idx_t rr_ptr_q;

   always_comb begin
      int cand;
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = int'(rr_ptr_q) + i;
         if (cand >= N_REQ) cand = cand - N_REQ;
         if (!pick_found && eligible[cand]) begin
            pick_found = 1'b1;
            pick_idx   = idx_t'(cand);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q <= '0;
      end else if (grant_now) begin
         rr_ptr_q <= (pick_idx == idx_t'(N_REQ - 1)) ? '0 : pick_idx + idx_t'(1);
      end
   end
`else
   // Scan from the top down so the lowest eligible index is the last one written.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            pick_found = 1'b1;
            pick_idx   = idx_t'(i);
         end
      end
   end
`endif

   // Memory pins follow the registered owner; anything else drives zeros.
   assign active     = (state_q == OWNED) & owner_req;
   assign read_issue = active & ~req_we[owner_q];

   always_comb begin
      mem_addr = '0;
      mem_data = '0;
      mem_wren = 1'b0;
      if (active) begin
         mem_addr = req_addr[int'(owner_q)*ADDR_W +: ADDR_W];
         mem_data = req_wdata[int'(owner_q)*DATA_W +: DATA_W];
         mem_wren = req_we[owner_q];
      end
   end

   // NOTE: the tag pipeline is reset (unlike a data RAM) so in-flight reads die with the session.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
      end else begin
         tag_q[0] <= '{valid: read_issue, idx: owner_q};
         for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   // Issuer index travels with the read, so a handover never redirects old data.
   always_comb begin
      rvalid = '0;
      if (tag_q[RD_LAT-1].valid) rvalid[tag_q[RD_LAT-1].idx] = 1'b1;
   end

   assign rdata = mem_q;
   assign gnt   = gnt_q;
   assign busy  = |gnt_q;

endmodule
